// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the templatized ALU and its result buffer.
//   NUM_UNITS / SEL_W : number of ALU sub-units and width of the unit select
//   alu_unit_e        : encoding of the unit select
//   alu_result_t      : one buffered ALU result at the default widths
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_TAG_W = 4;
    localparam int NUM_UNITS = 3;
    localparam int SEL_W     = $clog2(NUM_UNITS);

    typedef enum logic [SEL_W-1:0] {
        ADD   = 'd0,
        BOOL  = 'd1,
        SHIFT = 'd2
    } alu_unit_e;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] data;
        logic [SEL_W-1:0]     sel;
        logic [ALU_TAG_W-1:0] tag;
        logic                 zero;
        logic                 neg;
    } alu_result_t;

endpackage

// File: rtl/alu_fifo_mem.sv
// ---------------------------------------------------------------------------
// alu_fifo_mem
// DEPTH x ENTRY_W register array backing the ALU result buffer.
// Single synchronous write port, asynchronous read port. Contents are not
// reset; the owner masks anything read from an empty buffer.
//   clk   : write clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
// ---------------------------------------------------------------------------
module alu_fifo_mem
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = $bits(alu_result_t)
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ENTRY_W-1:0]       wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ENTRY_W-1:0]       rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_buffer.sv
// ---------------------------------------------------------------------------
// alu_result_buffer
// Captures each selected ALU result (with tag, source unit and derived
// zero/negative flags) into a DEPTH-entry FIFO for the writeback stage.
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   flush             : synchronous clear of all entries (wins over push/pop)
//   in_valid/in_ready : producer handshake, in_ready = !full
//   in_data/sel/tag   : ALU result, producing unit, request tag
//   out_valid/ready   : consumer handshake, out_valid = !empty
//   out_data/sel/tag  : head entry fields (zero while empty)
//   out_zero/out_neg  : flags captured with the head entry
//   count/full/empty  : occupancy status
// ---------------------------------------------------------------------------
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4,
    parameter int NUM_UNITS = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic [$clog2(NUM_UNITS)-1:0] in_sel,
    input  logic [TAG_W-1:0]             in_tag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(NUM_UNITS)-1:0] out_sel,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         out_zero,
    output logic                         out_neg,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SW    = $clog2(NUM_UNITS);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Same field layout as alu_result_t, sized by this instance's parameters.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SW-1:0]    sel;
        logic [TAG_W-1:0] tag;
        logic             zero;
        logic             neg;
    } entry_t;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;
    entry_t           wr_entry;
    entry_t           head;

    assign full      = (cnt == DEPTH_C);
    assign empty     = (cnt == '0);
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign count     = cnt;

    // A push coinciding with flush is dropped, so it must not touch storage either.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready;

    // Flags are captured at push time and travel with the entry.
    always_comb begin
        wr_entry      = '0;
        wr_entry.data = in_data;
        wr_entry.sel  = in_sel;
        wr_entry.tag  = in_tag;
        wr_entry.zero = (in_data == '0);
        wr_entry.neg  = in_data[WIDTH-1];
    end

    alu_fifo_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_W ($bits(entry_t))
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Unreset storage is hidden behind out_valid so an empty buffer reads as zero.
    always_comb begin
        out_data = '0;
        out_sel  = '0;
        out_tag  = '0;
        out_zero = 1'b0;
        out_neg  = 1'b0;
        if (out_valid) begin
            out_data = head.data;
            out_sel  = head.sel;
            out_tag  = head.tag;
            out_zero = head.zero;
            out_neg  = head.neg;
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;
    import alu_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic [SEL_W-1:0]  in_sel;
    logic [3:0]        in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [SEL_W-1:0]  out_sel;
    logic [3:0]        out_tag;
    logic              out_zero;
    logic              out_neg;
    logic [2:0]        count;
    logic              full;
    logic              empty;

    int n_checks;
    int n_fail;
    logic [3:0] exp_q[$];

    alu_result_buffer #(
        .WIDTH     (32),
        .DEPTH     (4),
        .TAG_W     (4),
        .NUM_UNITS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_tag   (out_tag),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] d, input logic [3:0] t);
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        in_sel   = BOOL;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_sel = ADD; in_tag = '0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({empty, full, out_valid, in_ready} !== 4'b1001) begin
            n_fail++;
            $display("FAIL reset_flags: got e/f/ov/ir=%b expected 1001", {empty, full, out_valid, in_ready});
        end
        n_checks++;
        if (count !== 3'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", count);
        end
        n_checks++;
        if ({out_data, out_tag, out_sel, out_zero, out_neg} !== '0) begin
            n_fail++;
            $display("FAIL reset_out_fields: got data=%h tag=%h sel=%h z=%b n=%b expected all 0",
                     out_data, out_tag, out_sel, out_zero, out_neg);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pass_through;
        in_valid = 1'b1; in_data = 32'h0000_0005; in_sel = ADD; in_tag = 4'd3; out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL pt_no_bypass: got out_valid=%b expected 0", out_valid);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_data, out_tag, out_zero, out_neg} !== {1'b1, 32'd5, 4'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL pt_head: got v=%b data=%h tag=%h z=%b n=%b expected v=1 data=5 tag=3 z=0 n=0",
                     out_valid, out_data, out_tag, out_zero, out_neg);
        end
        n_checks++;
        if (count !== 3'd1) begin
            n_fail++; $display("FAIL pt_count1: got %0d expected 1", count);
        end
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL pt_drained: got count=%0d empty=%b expected 0/1", count, empty);
        end
    endtask

    task automatic test_fill;
        logic [31:0] vals [4];
        vals[0] = 32'h0; vals[1] = 32'h8000_0000; vals[2] = 32'h1; vals[3] = 32'h2;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(vals[i], 4'(i));
        in_valid = 1'b1; in_data = 32'h5555_5555; in_tag = 4'd9;
        n_checks++;
        if ({full, in_ready, count} !== {1'b1, 1'b0, 3'd4}) begin
            n_fail++;
            $display("FAIL fill_full: got full=%b in_ready=%b count=%0d expected 1/0/4", full, in_ready, count);
        end
        tick(); tick();
        in_valid = 1'b0;
        n_checks++;
        if (count !== 3'd4) begin
            n_fail++; $display("FAIL fill_stall_count: got %0d expected 4", count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({out_tag, out_data, out_sel} !== {4'(i), vals[i], BOOL}) begin
                n_fail++;
                $display("FAIL fill_drain%0d: got tag=%h data=%h sel=%h expected tag=%h data=%h sel=1",
                         i, out_tag, out_data, out_sel, i, vals[i]);
            end
            n_checks++;
            if ({out_zero, out_neg} !== {(i == 0), (i == 1)}) begin
                n_fail++;
                $display("FAIL fill_flags%0d: got z=%b n=%b expected z=%b n=%b",
                         i, out_zero, out_neg, (i == 0), (i == 1));
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if (empty !== 1'b1) begin
            n_fail++; $display("FAIL fill_empty: got empty=%b expected 1 (fifth value stored?)", empty);
        end
    endtask

    task automatic test_full_push_pop;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'd10 + 32'(i), 4'(i));
        in_valid = 1'b1; in_data = 32'hAA; in_tag = 4'hA; in_sel = SHIFT; out_ready = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL fpp_in_ready_full: got %b expected 0", in_ready);
        end
        tick();
        out_ready = 1'b0;
        n_checks++;
        if ({count, in_ready, out_tag} !== {3'd3, 1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL fpp_pop_only: got count=%0d in_ready=%b tag=%h expected 3/1/1", count, in_ready, out_tag);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (count !== 3'd4) begin
            n_fail++; $display("FAIL fpp_refill: got count=%0d expected 4", count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_tag !== ((i == 3) ? 4'hA : 4'(i + 1))) begin
                n_fail++;
                $display("FAIL fpp_order%0d: got tag=%h expected %h", i, out_tag, (i == 3) ? 4'hA : 4'(i + 1));
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_streaming;
        exp_q.delete();
        out_ready = 1'b0;
        push_one(32'd100, 4'd14); exp_q.push_back(4'd14);
        push_one(32'd101, 4'd15); exp_q.push_back(4'd15);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_data = 32'd200 + 32'(k); in_tag = 4'(4 + k); out_ready = 1'b1;
            n_checks++;
            if (count !== 3'd2 || out_tag !== exp_q[0]) begin
                n_fail++;
                $display("FAIL stream%0d: got count=%0d tag=%h expected count=2 tag=%h", k, count, out_tag, exp_q[0]);
            end
            void'(exp_q.pop_front());
            exp_q.push_back(4'(4 + k));
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (out_tag !== exp_q[0] || out_data !== 32'd200 + 32'(exp_q[0] - 4'd4)) begin
                n_fail++;
                $display("FAIL stream_tail%0d: got tag=%h data=%0d expected tag=%h", k, out_tag, out_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(32'h30 + 32'(i), 4'(i));
        n_checks++;
        if (count !== 3'd3) begin
            n_fail++; $display("FAIL flush_pre_count: got %0d expected 3", count);
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h77; in_tag = 4'd7;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if ({count, empty, out_valid, out_data} !== {3'd0, 1'b1, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL flush_cleared: got count=%0d empty=%b ov=%b data=%h expected 0/1/0/0",
                     count, empty, out_valid, out_data);
        end
        push_one(32'h99, 4'd5);
        n_checks++;
        if ({count, out_tag, out_data} !== {3'd1, 4'd5, 32'h99}) begin
            n_fail++;
            $display("FAIL flush_after: got count=%0d tag=%h data=%h expected 1/5/99", count, out_tag, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        push_one(32'h1, 4'd1);
        push_one(32'h2, 4'd2);
        n_checks++;
        if (count !== 3'd2) begin
            n_fail++; $display("FAIL areset_pre_count: got %0d expected 2", count);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, count, empty} !== {1'b0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL areset_immediate: got ov=%b count=%0d empty=%b expected 0/0/1", out_valid, count, empty);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({out_valid, in_ready, count} !== {1'b0, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL areset_after: got ov=%b ir=%b count=%0d expected 0/1/0", out_valid, in_ready, count);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_pass_through();
        test_fill();
        test_full_push_pop();
        test_streaming();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
